firc_feeder: RTL and testbench

Initiator for the `firc` filter's input side. It holds a 15-entry complex coefficient shadow table and a small sample queue. It drives the filter's coefficient-load port (`PushCoef`/`CoefAddr`/`CoefI`/`CoefQ`) and its sample port (`PushIn`/`SampI`/`SampQ`), honouring the filter's `StopIn` back-pressure. It sits between the host/sample source and `firc`, so the filter never sees a push while stopped and never streams with an unloaded coefficient set.

---
 rtl/fir_structs.sv | 24 ++
 rtl/feeder_queue.sv | 59 +++++
 rtl/firc_feeder.sv | 151 +++++++++++++++
 tb/tb_firc_feeder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_structs.sv
// Shared types for the firc filter and its feeder: sample/coefficient pairs and feeder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_structs;

    localparam int NCOEF = 15;

    typedef struct packed {
        logic signed [23:0] I;
        logic signed [23:0] Q;
    } Samp;

    typedef struct packed {
        logic signed [26:0] I;
        logic signed [26:0] Q;
    } Coef;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_LOAD,
        FEED_STREAM
    } feed_state_t;

endpackage

// File: rtl/feeder_queue.sv
// Registered circular sample queue; head is zero while empty.
// Latency: an element written at edge N is visible on o_head from cycle N+1 (no bypass).
// Backpressure: caller must not push when o_full nor pop when o_empty.
module feeder_queue
    import fir_structs::*;
#(
    parameter int QDEPTH = 8
)(
    input  logic clk,
    input  logic Reset,
    input  logic i_push_vld,
    input  Samp  i_push_dat,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output Samp  o_head
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(QDEPTH);

    Samp            r_mem [QDEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (i_push_vld) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push_vld, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/firc_feeder.sv
// Feeds firc: shadow coefficient table loaded as a 15-cycle burst, then streams queued samples.
// Latency: LoadCoef at edge N -> pushes N+1..N+15, STREAM from N+16; sample enqueued at N pushable at N+1.
// Backpressure: StopIn combinationally gates PushIn (never coefficient pushes); SrcReady = queue not full.
module firc_feeder
    import fir_structs::Samp;
    import fir_structs::Coef;
    import fir_structs::feed_state_t;
    import fir_structs::FEED_IDLE;
    import fir_structs::FEED_LOAD;
    import fir_structs::FEED_STREAM;
#(
    parameter int QDEPTH = 8,
    parameter int NCOEF  = 15
)(
    input  logic                clk,
    input  logic                Reset,
    input  logic                HostCoefWe,
    input  logic [3:0]          HostCoefIdx,
    input  logic signed [26:0]  HostCoefI,
    input  logic signed [26:0]  HostCoefQ,
    input  logic                LoadCoef,
    input  logic                SrcValid,
    output logic                SrcReady,
    input  logic signed [23:0]  SrcI,
    input  logic signed [23:0]  SrcQ,
    input  logic                StopIn,
    output logic                PushCoef,
    output logic [4:0]          CoefAddr,
    output logic signed [26:0]  CoefI,
    output logic signed [26:0]  CoefQ,
    output logic                PushIn,
    output logic signed [23:0]  SampI,
    output logic signed [23:0]  SampQ,
    output logic                Busy,
    output logic                Loaded,
    output logic [31:0]         SampCount,
    output logic [15:0]         StallCount
);

    localparam logic [3:0] LAST_IDX = 4'(NCOEF - 1);

    feed_state_t r_state;
    feed_state_t w_state_nxt;
    logic [3:0]  r_load_idx;
    logic        r_loaded;
    Coef         r_shadow [NCOEF];
    logic [31:0] r_samp_cnt;
    logic [15:0] r_stall_cnt;

    logic        w_in_load;
    logic        w_push_in;
    logic        w_stall;
    logic        w_enq;
    logic        w_full;
    logic        w_empty;
    Samp         w_src;
    Samp         w_head;
    Coef         w_coef;

    // SrcReady is forced low while Reset is held so every output reads 0 in reset.
    assign SrcReady = !Reset && !w_full;
    assign w_enq    = SrcValid && SrcReady;
    assign w_src    = '{I: SrcI, Q: SrcQ};

    feeder_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .Reset      (Reset),
        .i_push_vld (w_enq),
        .i_push_dat (w_src),
        .i_pop      (w_push_in),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    // Next-state and per-cycle strobes; LoadCoef during LOAD is deliberately ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_in_load   = (r_state == FEED_LOAD);
        w_push_in   = (r_state == FEED_STREAM) && !w_empty && !StopIn;
        w_stall     = (r_state == FEED_STREAM) && !w_empty && StopIn;
        case (r_state)
            FEED_IDLE:   if (LoadCoef) w_state_nxt = FEED_LOAD;
            FEED_LOAD:   if (r_load_idx == LAST_IDX) w_state_nxt = FEED_STREAM;
            FEED_STREAM: if (LoadCoef) w_state_nxt = FEED_LOAD;
            default:     w_state_nxt = FEED_IDLE;
        endcase
    end

    // State register, burst index and the sticky loaded flag (set only by a finished burst).
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= FEED_IDLE;
            r_load_idx <= '0;
            r_loaded   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == FEED_LOAD && w_state_nxt == FEED_LOAD) begin
                r_load_idx <= r_load_idx + 1'b1;
            end else begin
                r_load_idx <= '0;
            end
            if (r_state == FEED_LOAD && r_load_idx == LAST_IDX) begin
                r_loaded <= 1'b1;
            end
        end
    end

    // Shadow table: host writes land in any state; index 15 is dropped.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (HostCoefWe && HostCoefIdx <= LAST_IDX) begin
            r_shadow[HostCoefIdx] <= '{I: HostCoefI, Q: HostCoefQ};
        end
    end

    // Pushed-sample counter (wrapping) and stall counter (saturating).
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_samp_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push_in) begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
            end
            if (w_stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // The entry goes out with whatever the shadow holds during its own send cycle.
    assign w_coef     = r_shadow[r_load_idx];
    assign PushCoef   = w_in_load;
    assign CoefAddr   = w_in_load ? ({1'b0, r_load_idx} + 5'd1) : 5'd0;
    assign CoefI      = w_in_load ? w_coef.I : '0;
    assign CoefQ      = w_in_load ? w_coef.Q : '0;
    assign PushIn     = w_push_in;
    assign SampI      = w_head.I;
    assign SampQ      = w_head.Q;
    assign Busy       = w_in_load;
    assign Loaded     = r_loaded;
    assign SampCount  = r_samp_cnt;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_firc_feeder.sv
// Bench for firc_feeder: directed scenarios with literal expectations plus random traffic.
// Latency: n/a.
// Backpressure: StopIn driven both directed and randomly.
module tb_firc_feeder;
    import fir_structs::*;

    localparam int QD = 8;

    logic               clk = 1'b0;
    logic               Reset = 1'b0;
    logic               HostCoefWe = 1'b0;
    logic [3:0]         HostCoefIdx = '0;
    logic signed [26:0] HostCoefI = '0;
    logic signed [26:0] HostCoefQ = '0;
    logic               LoadCoef = 1'b0;
    logic               SrcValid = 1'b0;
    logic               SrcReady;
    logic signed [23:0] SrcI = '0;
    logic signed [23:0] SrcQ = '0;
    logic               StopIn = 1'b0;
    logic               PushCoef;
    logic [4:0]         CoefAddr;
    logic signed [26:0] CoefI;
    logic signed [26:0] CoefQ;
    logic               PushIn;
    logic signed [23:0] SampI;
    logic signed [23:0] SampQ;
    logic               Busy;
    logic               Loaded;
    logic [31:0]        SampCount;
    logic [15:0]        StallCount;

    firc_feeder #(.QDEPTH(QD), .NCOEF(15)) dut (
        .clk(clk), .Reset(Reset),
        .HostCoefWe(HostCoefWe), .HostCoefIdx(HostCoefIdx),
        .HostCoefI(HostCoefI), .HostCoefQ(HostCoefQ),
        .LoadCoef(LoadCoef),
        .SrcValid(SrcValid), .SrcReady(SrcReady), .SrcI(SrcI), .SrcQ(SrcQ),
        .StopIn(StopIn),
        .PushCoef(PushCoef), .CoefAddr(CoefAddr), .CoefI(CoefI), .CoefQ(CoefQ),
        .PushIn(PushIn), .SampI(SampI), .SampQ(SampQ),
        .Busy(Busy), .Loaded(Loaded), .SampCount(SampCount), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 loading entry m_k, 2 streaming.
    int          m_mode;
    int          m_k;
    bit          m_loaded;
    Coef         m_shadow [15];
    Samp         m_q [$];
    logic [31:0] m_samp;
    int          m_stall;

    task automatic model_clear();
        m_mode = 0;
        m_k = 0;
        m_loaded = 0;
        for (int i = 0; i < 15; i++) m_shadow[i] = '0;
        m_q.delete();
        m_samp = '0;
        m_stall = 0;
    endtask

    initial model_clear();

    // Compare every cycle at the falling edge, then advance the model over the next rising edge.
    always @(negedge clk) begin
        bit          e_load;
        bit          e_push;
        bit          e_rdy;
        bit          e_stall;
        logic [26:0] e_ci;
        logic [26:0] e_cq;
        logic [23:0] e_si;
        logic [23:0] e_sq;
        if (Reset) model_clear();
        e_load  = (m_mode == 1);
        e_push  = (m_mode == 2) && (m_q.size() > 0) && !StopIn;
        e_stall = (m_mode == 2) && (m_q.size() > 0) && StopIn;
        e_rdy   = !Reset && (m_q.size() < QD);
        e_ci    = e_load ? m_shadow[m_k].I : '0;
        e_cq    = e_load ? m_shadow[m_k].Q : '0;
        e_si    = (m_q.size() > 0) ? m_q[0].I : '0;
        e_sq    = (m_q.size() > 0) ? m_q[0].Q : '0;
        check("PushCoef", 64'(PushCoef), 64'(e_load));
        check("CoefAddr", 64'(CoefAddr), e_load ? 64'(m_k + 1) : 64'd0);
        check("CoefI", 64'($unsigned(CoefI)), 64'(e_ci));
        check("CoefQ", 64'($unsigned(CoefQ)), 64'(e_cq));
        check("PushIn", 64'(PushIn), 64'(e_push));
        check("SampI", 64'($unsigned(SampI)), 64'(e_si));
        check("SampQ", 64'($unsigned(SampQ)), 64'(e_sq));
        check("SrcReady", 64'(SrcReady), 64'(e_rdy));
        check("Busy", 64'(Busy), 64'(e_load));
        check("Loaded", 64'(Loaded), 64'(m_loaded));
        check("SampCount", 64'(SampCount), 64'(m_samp));
        check("StallCount", 64'(StallCount), 64'(m_stall));
        if (!Reset) begin
            if (e_stall && m_stall < 65535) m_stall++;
            if (e_push) begin
                void'(m_q.pop_front());
                m_samp++;
            end
            if (SrcValid && e_rdy) m_q.push_back('{I: SrcI, Q: SrcQ});
            if (m_mode == 1) begin
                if (m_k == 14) begin
                    m_mode = 2;
                    m_k = 0;
                    m_loaded = 1;
                end else begin
                    m_k++;
                end
            end else if (LoadCoef) begin
                m_mode = 1;
                m_k = 0;
            end
            if (HostCoefWe && HostCoefIdx < 4'd15) m_shadow[HostCoefIdx] = '{I: HostCoefI, Q: HostCoefQ};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] got [8];
    int          tcy [8];
    int          n;
    logic [26:0] lit;

    initial begin
        #1 Reset = 1'b1;
        cyc();
        check("rst_Busy", 64'(Busy), 64'd0);
        check("rst_Loaded", 64'(Loaded), 64'd0);
        check("rst_SrcReady", 64'(SrcReady), 64'd0);
        Reset = 1'b0;
        #1 check("post_rst_SrcReady", 64'(SrcReady), 64'd1);

        // Shadow[k] = {k+1, -(k+1)}; index 15 must be ignored.
        for (int k = 0; k < 16; k++) begin
            HostCoefWe = 1'b1;
            HostCoefIdx = 4'(k);
            HostCoefI = (k == 15) ? 27'sd999 : 27'(k + 1);
            HostCoefQ = 27'(-(k + 1));
            cyc();
        end
        HostCoefWe = 1'b0;
        LoadCoef = 1'b1;
        cyc();
        LoadCoef = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("load_PushCoef", 64'(PushCoef), 64'd1);
            check("load_Addr", 64'(CoefAddr), 64'(k + 1));
            lit = 27'(k + 1);
            check("load_CoefI", 64'($unsigned(CoefI)), 64'(lit));
            lit = 27'(-(k + 1));
            check("load_CoefQ", 64'($unsigned(CoefQ)), 64'(lit));
        end
        @(negedge clk);
        check("load_done_Loaded", 64'(Loaded), 64'd1);
        check("load_done_PushCoef", 64'(PushCoef), 64'd0);
        cyc();

        // Five samples through an open filter: back-to-back, in order.
        n = 0;
        for (int i = 0; i < 8; i++) begin
            SrcValid = (i < 5);
            SrcI = 24'(i + 1);
            SrcQ = 24'(-(i + 1));
            @(negedge clk);
            if (PushIn && n < 8) begin
                got[n] = SampI;
                tcy[n] = i;
                n++;
            end
            cyc();
        end
        SrcValid = 1'b0;
        check("stream_npush", 64'(n), 64'd5);
        for (int j = 0; j < 5 && j < n; j++) check("stream_order", 64'(got[j]), 64'(j + 1));
        if (n == 5) check("stream_b2b", 64'(tcy[4] - tcy[0]), 64'd4);
        check("stream_SampCount", 64'(SampCount), 64'd5);

        // Fill the queue in IDLE; the ninth sample is refused.
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            SrcValid = 1'b1;
            SrcI = 24'(32'h100 + i);
            SrcQ = 24'(i);
            StopIn = i[0];
            cyc();
        end
        SrcValid = 1'b0;
        @(negedge clk);
        check("fill_SrcReady", 64'(SrcReady), 64'd0);
        check("fill_StallCount", 64'(StallCount), 64'd0);
        check("fill_head", 64'($unsigned(SampI)), 64'h100);
        cyc();

        // Three queued samples, StopIn high across LOAD and 4 STREAM cycles.
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        StopIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            SrcValid = 1'b1;
            SrcI = 24'(32'h200 + i);
            cyc();
        end
        SrcValid = 1'b0;
        LoadCoef = 1'b1;
        cyc();
        LoadCoef = 1'b0;
        repeat (15) cyc();
        check("stall_pre", 64'(StallCount), 64'd0);
        repeat (4) cyc();
        check("stall_4", 64'(StallCount), 64'd4);
        check("stall_nopush", 64'(SampCount), 64'd0);
        StopIn = 1'b0;
        repeat (4) cyc();
        check("stall_release", 64'(SampCount), 64'd3);
        check("stall_hold", 64'(StallCount), 64'd4);

        // Reload while streaming: one push, a 15-cycle hole, then the rest.
        StopIn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            SrcValid = 1'b1;
            SrcI = 24'(32'h300 + i);
            cyc();
        end
        SrcValid = 1'b0;
        StopIn = 1'b0;
        LoadCoef = 1'b1;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (PushIn && n < 8) begin
                got[n] = SampI;
                tcy[n] = i;
                n++;
            end
            cyc();
            LoadCoef = 1'b0;
        end
        check("reload_npush", 64'(n), 64'd6);
        for (int j = 0; j < 6 && j < n; j++) check("reload_order", 64'(got[j]), 64'(32'h300 + j));
        if (n >= 2) check("reload_gap", 64'(tcy[1] - tcy[0]), 64'd16);
        check("reload_SampCount", 64'(SampCount), 64'd9);

        // Reset in the middle of LOAD (entry 7).
        LoadCoef = 1'b1;
        cyc();
        LoadCoef = 1'b0;
        repeat (7) cyc();
        check("midload_addr", 64'(CoefAddr), 64'd8);
        Reset = 1'b1;
        #1;
        check("midrst_PushCoef", 64'(PushCoef), 64'd0);
        check("midrst_Addr", 64'(CoefAddr), 64'd0);
        check("midrst_Busy", 64'(Busy), 64'd0);
        check("midrst_Loaded", 64'(Loaded), 64'd0);
        check("midrst_SrcReady", 64'(SrcReady), 64'd0);
        cyc();
        Reset = 1'b0;
        LoadCoef = 1'b1;
        cyc();
        LoadCoef = 1'b0;
        @(negedge clk);
        check("restart_addr", 64'(CoefAddr), 64'd1);
        check("restart_coef", 64'($unsigned(CoefI)), 64'd0);
        cyc();
        repeat (15) cyc();
        check("restart_Loaded", 64'(Loaded), 64'd1);

        // Random traffic against the model.
        repeat (3000) begin
            Reset       = ($urandom_range(0, 999) == 0);
            LoadCoef    = ($urandom_range(0, 39) == 0);
            SrcValid    = ($urandom_range(0, 9) < 6);
            StopIn      = ($urandom_range(0, 9) < 3);
            SrcI        = 24'($urandom);
            SrcQ        = 24'($urandom);
            HostCoefWe  = ($urandom_range(0, 4) == 0);
            HostCoefIdx = 4'($urandom_range(0, 15));
            HostCoefI   = 27'($urandom);
            HostCoefQ   = 27'($urandom);
            cyc();
        end
        Reset = 1'b0;
        LoadCoef = 1'b0;
        SrcValid = 1'b0;
        HostCoefWe = 1'b0;
        StopIn = 1'b0;
        repeat (30) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
